scr1_imem_instr_profiler: RTL

//  Synthesisable, multi-channel instruction-class profiler on the IMEM response path.

---
 rtl/scr1_imem_instr_profiler_if.sv | 37 +++
 rtl/scr1_imem_instr_profiler.sv | 118 +++++++++++
 2 files changed

// File: rtl/scr1_imem_instr_profiler_if.sv
// Bus bundle between the IMEM response path / trace consumer and the instruction profiler.
// master = stimulus side (fetch path, config, trace sink); slave = the profiler.
interface scr1_imem_instr_profiler_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [1:0]            imem_resp;
    logic [31:0]           imem_rdata;
    logic [31:0]           curr_pc;
    logic [NUM_CH-1:0]     cfg_en;
    logic [NUM_CH*7-1:0]   cfg_opcode;
    logic [NUM_CH*3-1:0]   cfg_funct3;
    logic [NUM_CH-1:0]     cfg_f3_en;
    logic                  clr;
    logic [NUM_CH*CNT_W-1:0] cnt_out;
    logic [NUM_CH-1:0]     cnt_sat;
    logic                  trc_vld;
    logic                  trc_rdy;
    logic [CH_W-1:0]       trc_ch;
    logic [31:0]           trc_pc;
    logic [31:0]           trc_instr;
    logic                  trc_ovf;

    modport master (
        output imem_resp, imem_rdata, curr_pc,
        output cfg_en, cfg_opcode, cfg_funct3, cfg_f3_en, clr, trc_rdy,
        input  cnt_out, cnt_sat, trc_vld, trc_ch, trc_pc, trc_instr, trc_ovf
    );

    modport slave (
        input  imem_resp, imem_rdata, curr_pc,
        input  cfg_en, cfg_opcode, cfg_funct3, cfg_f3_en, clr, trc_rdy,
        output cnt_out, cnt_sat, trc_vld, trc_ch, trc_pc, trc_instr, trc_ovf
    );
endinterface

// File: rtl/scr1_imem_instr_profiler.sv
// Multi-channel instruction-class profiler: per-channel opcode/funct3 matching,
// saturating hit counters, and a trace FIFO of (channel, PC, instruction) per hitting fetch.
module scr1_imem_instr_profiler #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    scr1_imem_instr_profiler_if.slave bus
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic              flush_c;
    logic [NUM_CH-1:0] hit_c;
    logic [CH_W-1:0]   hit_ch_c;

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] sat_q, sat_d;

    logic [CH_W-1:0]   mem_ch    [FIFO_DEPTH];
    logic [31:0]       mem_pc    [FIFO_DEPTH];
    logic [31:0]       mem_instr [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              empty_c, full_c, pop_c, push_c, push_ok_c, drop_c;
    logic [AW-1:0]     rd_idx_c;

    // reset and clear share one path; clr also suppresses a same-cycle hit
    assign flush_c = ~rst_n | bus.clr;

    always_comb begin
        hit_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            hit_c[i] = (bus.imem_resp == 2'b01) & bus.cfg_en[i]
                     & (bus.imem_rdata[6:0] == bus.cfg_opcode[7*i +: 7])
                     & (~bus.cfg_f3_en[i] | (bus.imem_rdata[14:12] == bus.cfg_funct3[3*i +: 3]));
        end
    end

    // lowest-index hitting channel owns the trace entry
    always_comb begin
        hit_ch_c = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (hit_c[i]) hit_ch_c = CH_W'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (hit_c[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + CNT_W'(1);
            sat_d[i] = sat_q[i] | (cnt_d[i] == {CNT_W{1'b1}});
        end
    end

    always_ff @(posedge clk) begin
        if (flush_c) begin
            for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
            sat_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= cnt_d[i];
            sat_q <= sat_d;
        end
    end

    assign empty_c  = (wr_ptr_q == rd_ptr_q);
    assign full_c   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_c    = ~empty_c & bus.trc_rdy;
    assign push_c   = |hit_c;
    // a pop frees the slot on the same edge, so full+pop+push never drops
    assign push_ok_c = push_c & (~full_c | pop_c);
    assign drop_c    = push_c & full_c & ~pop_c;
    assign rd_idx_c  = rd_ptr_q[AW-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        ovf_d    = ovf_q | drop_c;
    end

    always_ff @(posedge clk) begin
        if (flush_c) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // storage needs no reset: reads are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (!flush_c && push_ok_c) begin
            mem_ch[wr_ptr_q[AW-1:0]]    <= hit_ch_c;
            mem_pc[wr_ptr_q[AW-1:0]]    <= bus.curr_pc;
            mem_instr[wr_ptr_q[AW-1:0]] <= bus.imem_rdata;
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_cnt_out
        assign bus.cnt_out[CNT_W*g +: CNT_W] = cnt_q[g];
    end

    assign bus.cnt_sat   = sat_q;
    assign bus.trc_ovf   = ovf_q;
    assign bus.trc_vld   = ~empty_c;
    assign bus.trc_ch    = empty_c ? '0 : mem_ch[rd_idx_c];
    assign bus.trc_pc    = empty_c ? '0 : mem_pc[rd_idx_c];
    assign bus.trc_instr = empty_c ? '0 : mem_instr[rd_idx_c];

endmodule
